// File: rtl/button_count_ctrl.sv
// Button front end: 2-flop sync + per-bit debounce + single-cycle inc/clr command pulses.
// Define AUTO_REPEAT_EN to build the held-increment auto-repeat (REPEAT state and timer).
module button_count_ctrl #(
   parameter int DEBOUNCE_CYCLES = 300000,
   parameter int REPEAT_DELAY    = 15000000,
   parameter int REPEAT_PERIOD   = 3000000
) (
   input  logic       clk30,
   input  logic       rst,
   input  logic [1:0] button,
   output logic       inc_pulse,
   output logic       clr_pulse,
   output logic [1:0] btn_level
);

   localparam int MAX_CYC = (DEBOUNCE_CYCLES > REPEAT_DELAY)
      ? ((DEBOUNCE_CYCLES > REPEAT_PERIOD) ? DEBOUNCE_CYCLES : REPEAT_PERIOD)
      : ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
   localparam int CW = $clog2(MAX_CYC) + 1;

`ifdef AUTO_REPEAT_EN
   typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;
`else
   typedef enum logic [1:0] {IDLE, HELD} state_t;
`endif

   logic [1:0] sync1_q, sync2_q;
   logic [1:0] synced;
   logic [1:0] level_prev_q;
   state_t     state_q, state_d;
   logic       inc_block_q, inc_block_d;
   logic       inc_pulse_q, inc_pulse_d;
   logic       clr_pulse_q, clr_pulse_d;
   logic       clr_edge, inc_edge;
`ifdef AUTO_REPEAT_EN
   logic [CW-1:0] timer_q, timer_d;
`endif

   // Synchronisers idle at 1 so a button held through reset is seen as a new press.
   always_ff @(posedge clk30 or posedge rst) begin
      if (rst) begin
         sync1_q <= 2'b11;
         sync2_q <= 2'b11;
      end else begin
         sync1_q <= button;
         sync2_q <= sync1_q;
      end
   end

   assign synced = ~sync2_q;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_debounce
         logic [CW-1:0] cnt_q;
         logic          level_q;

         always_ff @(posedge clk30 or posedge rst) begin
            if (rst) begin
               cnt_q   <= '0;
               level_q <= 1'b0;
            end else if (synced[gi] == level_q) begin
               cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
               level_q <= synced[gi];
               cnt_q   <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end

         assign btn_level[gi] = level_q;
      end
   endgenerate

   assign clr_edge = btn_level[0] & ~level_prev_q[0];
   assign inc_edge = btn_level[1] & ~level_prev_q[1];

   always_comb begin
      state_d     = state_q;
      inc_block_d = inc_block_q;
      inc_pulse_d = 1'b0;
      clr_pulse_d = 1'b0;
`ifdef AUTO_REPEAT_EN
      timer_d     = timer_q;
`endif
      if (clr_edge) begin
         // Clear wins over everything, and inc must be released before it counts again.
         clr_pulse_d = 1'b1;
         inc_block_d = 1'b1;
         state_d     = IDLE;
`ifdef AUTO_REPEAT_EN
         timer_d     = '0;
`endif
      end else begin
         if (!btn_level[1]) inc_block_d = 1'b0;
         case (state_q)
            IDLE: begin
               if (inc_edge && !inc_block_q) begin
                  inc_pulse_d = 1'b1;
                  state_d     = HELD;
`ifdef AUTO_REPEAT_EN
                  timer_d     = '0;
`endif
               end
            end
            HELD: begin
               if (!btn_level[1]) begin
                  state_d = IDLE;
`ifdef AUTO_REPEAT_EN
               end else if (timer_q == CW'(REPEAT_DELAY - 1)) begin
                  inc_pulse_d = 1'b1;
                  timer_d     = '0;
                  state_d     = REPEAT;
               end else begin
                  timer_d = timer_q + 1'b1;
`endif
               end
            end
`ifdef AUTO_REPEAT_EN
            REPEAT: begin
               if (!btn_level[1]) begin
                  state_d = IDLE;
               end else if (timer_q == CW'(REPEAT_PERIOD - 1)) begin
                  inc_pulse_d = 1'b1;
                  timer_d     = '0;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
`endif
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk30 or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         level_prev_q <= 2'b00;
         inc_block_q  <= 1'b0;
         inc_pulse_q  <= 1'b0;
         clr_pulse_q  <= 1'b0;
`ifdef AUTO_REPEAT_EN
         timer_q      <= '0;
`endif
      end else begin
         state_q      <= state_d;
         level_prev_q <= btn_level;
         inc_block_q  <= inc_block_d;
         inc_pulse_q  <= inc_pulse_d;
         clr_pulse_q  <= clr_pulse_d;
`ifdef AUTO_REPEAT_EN
         timer_q      <= timer_d;
`endif
      end
   end

   assign inc_pulse = inc_pulse_q;
   assign clr_pulse = clr_pulse_q;

endmodule
